serial_subtractor: RTL and testbench

- Bit-serial unsigned/two's-complement subtractor computing D = A − B, LSB-first, one bit per clock, with a single borrow flip-flop.
- Subtraction counterpart to the combinational ripple adder path; trades area for latency.
- Operands enter and results leave through valid/ready handshakes so it drops into the add/subtract datapath alongside the adder.

---
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor computing diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock through a single borrow flip-flop. Operands arrive on a
// valid/ready handshake and the result is presented on a second valid/ready
// handshake. It is held until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair a/b is valid
//   in_ready   block can accept operands (high only while idle)
//   a          minuend, WIDTH bits
//   b          subtrahend, WIDTH bits
//   out_valid  diff/borrow/overflow are valid, held until accepted
//   out_ready  consumer accepts the result
//   diff       a - b mod 2^WIDTH
//   borrow     unsigned borrow, set iff a < b as unsigned numbers
//   overflow   signed (two's-complement) overflow of a - b
//   busy       an operation is in progress or its result is waiting
//
// Timing: out_valid rises exactly WIDTH clock edges after the accept edge.
// With out_ready held high, one operation completes every WIDTH+2 cycles.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // The minuend register doubles as the difference shift register. Each
    // difference bit is pushed into the MSB that the right shift vacates, so
    // after WIDTH steps the register holds the whole result.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;

    logic [1:0]       step;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
    logic             accept;

    // One full-subtractor step. It returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi,
                                           input logic bri);
        logic d;
        logic bro;
        d   = ai ^ bi ^ bri;
        bro = (~ai & bi) | (~(ai ^ bi) & bri);
        return {bro, d};
    endfunction

    assign step     = sub_bit(a_sr[0], b_sr[0], br);
    assign d_bit    = step[0];
    assign br_nxt   = step[1];
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = (state == IDLE) && in_valid;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Serial datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                cnt   <= '0;
                br    <= 1'b0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end else if (state == SHIFT) begin
                a_sr <= {d_bit, a_sr[WIDTH-1:1]};
                b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                br   <= br_nxt;
                cnt  <= cnt + CW'(1);
                if (last_bit) begin
                    diff_q     <= {d_bit, a_sr[WIDTH-1:1]};
                    borrow_q   <= br_nxt;
                    // Signed overflow happens only when the operand signs
                    // differ and the result sign disagrees with the minuend.
                    overflow_q <= (a_msb != b_msb) && (d_bit != a_msb);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ediff;
        logic         eborrow;
        logic         eovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents an operand pair at a falling edge and returns just after the
    // accept edge. Afterwards the inputs are scrambled so that the design
    // has to rely on its own latched copies.
    task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
        @(negedge clk);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    // Counts the edges after the accept edge until out_valid appears.
    task automatic wait_result;
        int n;
        n = 0;
        while (!out_valid && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, W);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ed,
                                input logic eb, input logic eo);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
        vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        vecs[8] = '{8'hC0, 8'h40, 8'h80, 1'b0, 1'b0};
        vecs[9] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Table-driven operations with out_ready held high
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].va, vecs[i].vb);
            wait_result();
            check_result($sformatf("vec%0d", i), vecs[i].ediff,
                         vecs[i].eborrow, vecs[i].eovf);
            @(negedge clk);
            check("vec_out_valid_cleared", {31'd0, out_valid}, 32'd0);
            check("vec_in_ready_back", {31'd0, in_ready}, 32'd1);
        end

        // Backpressure: the result is held while out_ready stays low
        out_ready = 1'b0;
        start_op(8'h00, 8'h01);
        wait_result();
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_result("bp", 8'hFF, 1'b1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_released_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_released_in_ready", {31'd0, in_ready}, 32'd1);
        check_result("bp_retained", 8'hFF, 1'b1, 1'b0);

        // An operand offer made during SHIFT must be ignored
        start_op(8'h12, 8'h35);
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        check("ignore_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && checks < 100000) @(negedge clk);
        check_result("ignore", 8'hDD, 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < W + 2; k++) begin
            check("ignore_no_second", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of an operation aborts it
        start_op(8'h35, 8'h12);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check_result("midrst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start_op(8'h10, 8'h10);
        wait_result();
        check_result("after_rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("after_rst_idle", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
